// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: register map, CTRL/STAT bit positions
// and the FSM state encoding.
package spi_master_pkg;

  // IO-slot register addresses
  localparam logic [3:0] REG_DATA = 4'h0;
  localparam logic [3:0] REG_STAT = 4'h1;
  localparam logic [3:0] REG_CTRL = 4'h2;
  localparam logic [3:0] REG_DIV  = 4'h3;

  // CTRL bit positions
  localparam int unsigned CTRL_CS_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_MRDY   = 2;

  // STAT bit positions
  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_RX_VALID  = 1;
  localparam int unsigned STAT_SLAVE_RDY = 2;
  localparam int unsigned STAT_OVERRUN   = 3;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitRdy = 3'd1,
    StSetup   = 3'd2,
    StHigh    = 3'd3,
    StLow     = 3'd4,
    StDone    = 3'd5
  } state_e;

  // Assemble the STAT read value from its individual flags.
  function automatic logic [7:0] pack_stat(input logic overrun, input logic slave_rdy,
                                           input logic rx_valid, input logic busy);
    logic [7:0] stat;
    stat                 = 8'h00;
    stat[STAT_OVERRUN]   = overrun;
    stat[STAT_SLAVE_RDY] = slave_rdy;
    stat[STAT_RX_VALID]  = rx_valid;
    stat[STAT_BUSY]      = busy;
    return stat;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// CPU IO-bus view of the SPI master slot. Signal suffixes are as seen from the
// SPI master; the "slave" modport is the peripheral, "master" the CPU side.
interface spi_master_if;
  logic [3:0] A_i;
  logic [7:0] D_i;
  logic [7:0] D_o;
  logic       nWR_i;
  logic       nRD_i;
  logic       interrupt_o;

  modport slave (
    input  A_i, D_i, nWR_i, nRD_i,
    output D_o, interrupt_o
  );

  modport master (
    output A_i, D_i, nWR_i, nRD_i,
    input  D_o, interrupt_o
  );
endinterface

// File: rtl/spi_master_clkgen.sv
// Half-period tick generator: down-counter reloaded with div_i, tick_o is high
// for the single cycle in which the counter reaches zero.
module spi_master_clkgen (
  input  logic       clk_i,
  input  logic       n_reset_i,
  input  logic       restart_i,
  input  logic [7:0] div_i,
  output logic       tick_o
);

  logic [7:0] cnt_q;

  assign tick_o = (cnt_q == 8'd0);

  // Count down and reload on each tick or on an explicit restart
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      cnt_q <= 8'd0;
    end else if (restart_i || tick_o) begin
      cnt_q <= div_i;
    end else begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first, one byte per transfer, on a 16-address IO slot.
// Build option: define SPI_MASTER_HANDSHAKE_EN to gate the start of each
// transfer on the synchronised slave_rdy_i; otherwise slave_rdy_i is ignored.
module spi_master
  import spi_master_pkg::*;
#(
  parameter logic [7:0]  DIV_DEFAULT = 8'd3,
  parameter int unsigned SYNC_STAGES = 2  // legal 2..3
) (
  input  logic         clk_i,
  input  logic         n_reset_i,
  spi_master_if.slave  bus,
  output logic         sck_o,
  output logic         mosi_o,
  input  logic         miso_i,
  output logic         cs_o,
  output logic         master_rdy_o,
  input  logic         slave_rdy_i
);

  state_e     state_q, state_d;
  logic       nwr_q, nrd_q;
  logic [3:0] rd_addr_q;
  logic [2:0] ctrl_q;
  logic [7:0] div_q, div_act_q;
  logic [7:0] tx_q, rx_sh_q, rx_q;
  logic       rx_valid_q, overrun_q;
  logic [2:0] bit_cnt_q;
  logic       sck_q, mosi_q;

  logic       wr_en, rd_end, busy, data_wr, start;
  logic       restart, tick;
  logic       miso_sync, rdy_sync, rdy_ok;

  logic [SYNC_STAGES-1:0] miso_sync_q;

  // Write acts on the first low cycle of nWR_i; read side effects on nRD_i rising
  assign wr_en   = ~bus.nWR_i & nwr_q;
  assign rd_end  = bus.nRD_i & ~nrd_q;
  assign busy    = (state_q != StIdle);
  assign data_wr = wr_en && (bus.A_i == REG_DATA);
  assign start   = data_wr && !busy;

  // MISO synchroniser
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      miso_sync_q <= '0;
    end else begin
      miso_sync_q <= {miso_sync_q[SYNC_STAGES-2:0], miso_i};
    end
  end
  assign miso_sync = miso_sync_q[SYNC_STAGES-1];

`ifdef SPI_MASTER_HANDSHAKE_EN
  logic [SYNC_STAGES-1:0] rdy_sync_q;

  // slave_rdy_i synchroniser
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      rdy_sync_q <= '0;
    end else begin
      rdy_sync_q <= {rdy_sync_q[SYNC_STAGES-2:0], slave_rdy_i};
    end
  end
  assign rdy_sync = rdy_sync_q[SYNC_STAGES-1];
  assign rdy_ok   = rdy_sync;
`else
  logic unused_slave_rdy;
  assign unused_slave_rdy = slave_rdy_i;
  assign rdy_sync         = 1'b0;
  assign rdy_ok           = 1'b1;
`endif

  spi_master_clkgen u_clkgen (
    .clk_i     (clk_i),
    .n_reset_i (n_reset_i),
    .restart_i (restart),
    .div_i     (div_act_q),
    .tick_o    (tick)
  );

  // Strobe edge detection and read-address capture
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      nwr_q     <= 1'b1;
      nrd_q     <= 1'b1;
      rd_addr_q <= 4'h0;
    end else begin
      nwr_q <= bus.nWR_i;
      nrd_q <= bus.nRD_i;
      if (!bus.nRD_i) begin
        rd_addr_q <= bus.A_i;
      end
    end
  end

  // CTRL and DIV registers
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      ctrl_q <= 3'b000;
      div_q  <= DIV_DEFAULT;
    end else if (wr_en) begin
      if (bus.A_i == REG_CTRL) begin
        ctrl_q <= bus.D_i[2:0];
      end
      if (bus.A_i == REG_DIV) begin
        div_q <= bus.D_i;
      end
    end
  end

  // Status flags; a setting event wins over a same-cycle read clear
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (state_q == StDone) begin
        rx_valid_q <= 1'b1;
      end else if (rd_end && (rd_addr_q == REG_DATA)) begin
        rx_valid_q <= 1'b0;
      end
      if (data_wr && busy) begin
        overrun_q <= 1'b1;
      end else if (rd_end && (rd_addr_q == REG_STAT)) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; restart aligns the divider with SETUP entry
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (rdy_ok) begin
          state_d = StSetup;
          restart = 1'b1;
        end
      end
      StSetup: begin
        if (tick) begin
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (tick) begin
          state_d = (bit_cnt_q == 3'd7) ? StDone : StLow;
        end
      end
      StLow: begin
        if (tick) begin
          state_d = StHigh;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Shift datapath and SPI pins; MISO is sampled on the last HIGH cycle
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      tx_q      <= 8'h00;
      rx_sh_q   <= 8'h00;
      rx_q      <= 8'h00;
      div_act_q <= DIV_DEFAULT;
      bit_cnt_q <= 3'd0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      if (start) begin
        tx_q      <= bus.D_i;
        mosi_q    <= bus.D_i[7];
        div_act_q <= div_q;
        bit_cnt_q <= 3'd0;
      end
      case (state_q)
        StSetup: begin
          if (tick) begin
            sck_q <= 1'b1;
          end
        end
        StHigh: begin
          if (tick) begin
            rx_sh_q <= {rx_sh_q[6:0], miso_sync};
            sck_q   <= 1'b0;
            if (bit_cnt_q != 3'd7) begin
              tx_q      <= {tx_q[6:0], 1'b0};
              mosi_q    <= tx_q[6];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        StLow: begin
          if (tick) begin
            sck_q <= 1'b1;
          end
        end
        StDone: begin
          rx_q      <= rx_sh_q;
          mosi_q    <= 1'b0;
          bit_cnt_q <= 3'd0;
        end
        default: ;
      endcase
    end
  end

  // Register read mux, combinational from the address
  always_comb begin
    bus.D_o = 8'h00;
    case (bus.A_i)
      REG_DATA: bus.D_o = rx_q;
      REG_STAT: bus.D_o = pack_stat(overrun_q, rdy_sync, rx_valid_q, busy);
      REG_CTRL: bus.D_o = {5'b00000, ctrl_q};
      REG_DIV:  bus.D_o = div_q;
      default:  bus.D_o = 8'h00;
    endcase
  end

  assign bus.interrupt_o = rx_valid_q & ctrl_q[CTRL_IRQ_EN];
  assign sck_o           = sck_q;
  assign mosi_o          = mosi_q;
  assign cs_o            = ~ctrl_q[CTRL_CS_EN];
  assign master_rdy_o    = ctrl_q[CTRL_MRDY];

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: register access, loopback transfers,
// handshake gating, overrun, divider timing and reset during a transfer.
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int unsigned SyncStages = 2;
`ifdef SPI_MASTER_HANDSHAKE_EN
  localparam logic [7:0] RdyBit = 8'h04;
`else
  localparam logic [7:0] RdyBit = 8'h00;
`endif

  logic clk_i = 1'b0;
  logic n_reset_i;
  logic sck_o, mosi_o, miso_i, cs_o, master_rdy_o, slave_rdy_i;
  logic loop_en, miso_drv;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  assign miso_i = loop_en ? mosi_o : miso_drv;

  spi_master_if bus ();

  spi_master #(
    .DIV_DEFAULT (8'd3),
    .SYNC_STAGES (SyncStages)
  ) dut (
    .clk_i        (clk_i),
    .n_reset_i    (n_reset_i),
    .bus          (bus),
    .sck_o        (sck_o),
    .mosi_o       (mosi_o),
    .miso_i       (miso_i),
    .cs_o         (cs_o),
    .master_rdy_o (master_rdy_o),
    .slave_rdy_i  (slave_rdy_i)
  );

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk_i);
    bus.A_i   = a;
    bus.D_i   = d;
    bus.nWR_i = 1'b0;
    @(negedge clk_i);
    bus.nWR_i = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk_i);
    bus.A_i   = a;
    bus.nRD_i = 1'b0;
    #1 d = bus.D_o;
    @(negedge clk_i);
    bus.nRD_i = 1'b1;
  endtask

  // Look at a register without a read strobe (no side effects)
  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk_i);
    bus.A_i = a;
    #1 d = bus.D_o;
  endtask

  // Behave as an SPI slave observer: collect MOSI at each SCK rise, measure every
  // phase and the cycles from the first rise until STAT.busy drops.
  task automatic monitor_transfer(input int div, output logic [7:0] bits, output int pulses,
                                  output int bad_phase, output int tcycles,
                                  output bit timed_out);
    int  phase_len = 0;
    bit  started   = 1'b0;
    logic prev     = 1'b0;
    bits = 8'h00; pulses = 0; bad_phase = 0; tcycles = 0; timed_out = 1'b1;
    bus.A_i = REG_STAT;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk_i);
      #1;
      if (sck_o && !prev) begin
        if (pulses > 0 && phase_len != div + 1) bad_phase++;
        if (pulses < 8) bits = {bits[6:0], mosi_o};
        pulses++;
        phase_len = 1;
        if (!started) begin
          started = 1'b1;
          tcycles = -1;
        end
      end else if (!sck_o && prev) begin
        if (phase_len != div + 1) bad_phase++;
        phase_len = 1;
      end else begin
        phase_len++;
      end
      prev = sck_o;
      if (started) tcycles++;
      if (started && !bus.D_o[0]) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Full transfer checks against the byte written and the divider in force
  task automatic check_transfer(input string name, input int div, input logic [7:0] tx);
    logic [7:0] bits;
    int pulses, bad, tc;
    bit to;
    // SETUP lasts div+1 cycles before the first rise, so the rise-to-idle time
    // is the total transfer time minus one half-period.
    int exp_tc;
    exp_tc = 16 * (div + 1) + 1 - (div + 1);
    monitor_transfer(div, bits, pulses, bad, tc, to);
    checks++;
    if (to !== 1'b0) begin
      failures++; $display("FAIL %s_timeout got=%0d want=0", name, to);
    end
    checks++;
    if (pulses !== 8) begin
      failures++; $display("FAIL %s_pulses got=%0d want=8", name, pulses);
    end
    checks++;
    if (bits !== tx) begin
      failures++; $display("FAIL %s_mosi got=%02h want=%02h", name, bits, tx);
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL %s_phase bad_phases=%0d want=0", name, bad);
    end
    checks++;
    if (tc !== exp_tc) begin
      failures++; $display("FAIL %s_time got=%0d want=%0d", name, tc, exp_tc);
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    n_reset_i = 1'b0; slave_rdy_i = 1'b0; loop_en = 1'b0; miso_drv = 1'b0;
    bus.A_i = REG_DATA; bus.D_i = 8'h00; bus.nWR_i = 1'b1; bus.nRD_i = 1'b1;
    #1;
    checks++;
    if ({sck_o, cs_o, mosi_o, bus.interrupt_o, master_rdy_o} !== 5'b01000) begin
      failures++;
      $display("FAIL reset_pins got=%b want=01000",
               {sck_o, cs_o, mosi_o, bus.interrupt_o, master_rdy_o});
    end
    checks++;
    if (bus.D_o !== 8'h00) begin
      failures++; $display("FAIL reset_rx got=%02h want=00", bus.D_o);
    end
    repeat (3) @(negedge clk_i);
    n_reset_i = 1'b1;
    peek(REG_STAT, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL reset_stat got=%02h want=00", d);
    end
    peek(REG_DIV, d);
    checks++;
    if (d !== 8'h03) begin
      failures++; $display("FAIL reset_div got=%02h want=03", d);
    end
    peek(REG_CTRL, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL reset_ctrl got=%02h want=00", d);
    end
    slave_rdy_i = 1'b1;
    repeat (4) @(negedge clk_i);
    peek(REG_STAT, d);
    checks++;
    if (d !== RdyBit) begin
      failures++; $display("FAIL reset_stat_rdy got=%02h want=%02h", d, RdyBit);
    end
  endtask

  task automatic test_loopback_min_div;
    logic [7:0] d;
    loop_en = 1'b1;
    bus_write(REG_DIV, 8'h00);
    bus_write(REG_CTRL, 8'h07);
    checks++;
    if ({cs_o, master_rdy_o} !== 2'b01) begin
      failures++; $display("FAIL ctrl_pins got=%b want=01", {cs_o, master_rdy_o});
    end
    bus_write(REG_DATA, 8'hA5);
    check_transfer("mindiv", 0, 8'hA5);
    checks++;
    if (bus.interrupt_o !== 1'b1) begin
      failures++; $display("FAIL mindiv_irq got=%b want=1", bus.interrupt_o);
    end
    bus_read(REG_DATA, d);
    @(negedge clk_i);
    #1;
    checks++;
    if (bus.interrupt_o !== 1'b0) begin
      failures++; $display("FAIL mindiv_irq_clear got=%b want=0", bus.interrupt_o);
    end
  endtask

  // Received byte is only checked at divisors the MISO synchroniser can meet
  task automatic test_loopback;
    logic [7:0] d, tx;
    int div;
    loop_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      div = (i == 0) ? 2 : int'($urandom_range(2, 5));
      tx  = (i == 0) ? 8'hA5 : 8'($urandom);
      bus_write(REG_DIV, 8'(div));
      bus_write(REG_DATA, tx);
      check_transfer("loop", div, tx);
      peek(REG_STAT, d);
      checks++;
      if (d !== (8'h02 | RdyBit)) begin
        failures++; $display("FAIL loop_stat got=%02h want=%02h", d, 8'h02 | RdyBit);
      end
      checks++;
      if (bus.interrupt_o !== 1'b1) begin
        failures++; $display("FAIL loop_irq got=%b want=1", bus.interrupt_o);
      end
      bus_read(REG_DATA, d);
      checks++;
      if (d !== tx) begin
        failures++; $display("FAIL loop_rx got=%02h want=%02h", d, tx);
      end
      @(negedge clk_i);
      #1;
      checks++;
      if (bus.interrupt_o !== 1'b0) begin
        failures++; $display("FAIL loop_irq_clear got=%b want=0", bus.interrupt_o);
      end
    end
  endtask

  task automatic test_handshake;
    logic [7:0] d;
    int cnt;
    bit seen;
    loop_en = 1'b1;
    bus_write(REG_DIV, 8'd2);
    slave_rdy_i = 1'b0;
    repeat (4) @(negedge clk_i);
    bus_write(REG_DATA, 8'h3C);
`ifdef SPI_MASTER_HANDSHAKE_EN
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (sck_o) cnt++;
    end
    checks++;
    if (cnt !== 0) begin
      failures++; $display("FAIL hs_sck_held high_cycles=%0d want=0", cnt);
    end
    peek(REG_STAT, d);
    checks++;
    if (d !== 8'h01) begin
      failures++; $display("FAIL hs_stat got=%02h want=01", d);
    end
    slave_rdy_i = 1'b1;
`endif
    seen = 1'b0;
    cnt  = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk_i);
      cnt++;
      if (sck_o) seen = 1'b1;
    end
    checks++;
`ifdef SPI_MASTER_HANDSHAKE_EN
    if (!seen || cnt > int'(SyncStages) + 2 + 3) begin
      failures++;
      $display("FAIL hs_start seen=%0d cycles=%0d want<=%0d", seen, cnt, SyncStages + 5);
    end
`else
    if (!seen || cnt != 4) begin
      failures++; $display("FAIL hs_start seen=%0d cycles=%0d want=4", seen, cnt);
    end
`endif
    slave_rdy_i = 1'b1;
    bus.A_i = REG_STAT;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk_i);
      #1;
      if (!bus.D_o[0]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL hs_done got=busy want=idle");
    end
    bus_read(REG_DATA, d);
    checks++;
    if (d !== 8'h3C) begin
      failures++; $display("FAIL hs_rx got=%02h want=3c", d);
    end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    loop_en = 1'b1;
    slave_rdy_i = 1'b1;
    bus_write(REG_DIV, 8'd2);
    bus_write(REG_DATA, 8'h11);
    bus_write(REG_DATA, 8'h22);
    check_transfer("ovr", 2, 8'h11);
    peek(REG_STAT, d);
    checks++;
    if (d !== (8'h0A | RdyBit)) begin
      failures++; $display("FAIL ovr_stat got=%02h want=%02h", d, 8'h0A | RdyBit);
    end
    bus_read(REG_STAT, d);
    peek(REG_STAT, d);
    checks++;
    if (d[3] !== 1'b0) begin
      failures++; $display("FAIL ovr_clear got=%b want=0", d[3]);
    end
    bus_read(REG_DATA, d);
    checks++;
    if (d !== 8'h11) begin
      failures++; $display("FAIL ovr_rx got=%02h want=11", d);
    end
  endtask

  task automatic test_divider;
    logic [7:0] d, tx;
    tx = 8'($urandom);
    bus_write(REG_DIV, 8'd4);
    bus_write(REG_DATA, tx);
    bus_write(REG_DIV, 8'd1);
    check_transfer("div4", 4, tx);
    peek(REG_DIV, d);
    checks++;
    if (d !== 8'h01) begin
      failures++; $display("FAIL div_readback got=%02h want=01", d);
    end
    bus_write(REG_DATA, ~tx);
    check_transfer("div1", 1, ~tx);
    bus_read(REG_DATA, d);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d, tx;
    int rises;
    logic prev;
    loop_en = 1'b1;
    bus_write(REG_DIV, 8'd2);
    bus_write(REG_CTRL, 8'h07);
    bus_write(REG_DATA, 8'($urandom));
    bus.A_i = REG_STAT;
    rises = 0;
    prev  = 1'b0;
    for (int n = 0; n < 500 && rises < 3; n++) begin
      @(negedge clk_i);
      if (sck_o && !prev) rises++;
      prev = sck_o;
    end
    checks++;
    if (rises !== 3) begin
      failures++; $display("FAIL rstmid_rises got=%0d want=3", rises);
    end
    #2 n_reset_i = 1'b0;
    #1;
    checks++;
    if ({sck_o, cs_o, bus.D_o[0], mosi_o} !== 4'b0100) begin
      failures++;
      $display("FAIL rstmid_pins got=%b want=0100", {sck_o, cs_o, bus.D_o[0], mosi_o});
    end
    @(negedge clk_i);
    n_reset_i = 1'b1;
    tx = 8'($urandom);
    bus_write(REG_DIV, 8'd2);
    bus_write(REG_CTRL, 8'h07);
    bus_write(REG_DATA, tx);
    check_transfer("rstmid", 2, tx);
    bus_read(REG_DATA, d);
    checks++;
    if (d !== tx) begin
      failures++; $display("FAIL rstmid_rx got=%02h want=%02h", d, tx);
    end
  endtask

  initial begin
    test_reset();
    test_loopback_min_div();
    test_loopback();
    test_handshake();
    test_overrun();
    test_divider();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
